// File: rtl/pick_sync.sv
// rtl/pick_sync.sv - sync-header hunter that qualifies the following payload words as pixels
module pick_sync #(
  parameter int                 DATA_W      = 16,
  parameter logic [DATA_W-1:0]  PRE_WORD    = 16'hFFFF,
  parameter int                 PRE_CNT     = 2,
  parameter logic [DATA_W-1:0]  MARK_WORD   = 16'hAAAA,
  parameter int                 PAYLOAD_LEN = 16,
  parameter int                 LCNT_W      = 8
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic                           EN,
  input  logic [DATA_W-1:0]              DIN,
  output logic                           PIXEL_VALID,
  output logic [DATA_W-1:0]              PIXEL_DATA,
  output logic                           PIXEL_FIRST,
  output logic                           PIXEL_LAST,
  output logic [$clog2(PAYLOAD_LEN)-1:0] PIXEL_INDEX,
  output logic [LCNT_W-1:0]              LINE_CNT,
  output logic                           SYNC_ERR
);

  localparam int IDX_W = $clog2(PAYLOAD_LEN);
  localparam int PC_W  = $clog2(PRE_CNT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);
  localparam logic [PC_W-1:0]  PRE_MIN  = PC_W'(PRE_CNT);

  typedef enum logic [1:0] {HUNT, PRE, PAYLOAD} state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pre_cnt_q, pre_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    pix_idx_q, pix_idx_d;
  logic [LCNT_W-1:0]   line_cnt_q, line_cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                first_q, first_d;
  logic                last_q, last_d;
  logic                err_q, err_d;

  // Next-state and registered-output logic; nothing advances on a disabled word.
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    idx_d      = idx_q;
    pix_idx_d  = pix_idx_q;
    line_cnt_d = line_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    first_d    = 1'b0;
    last_d     = 1'b0;
    err_d      = 1'b0;
    if (EN) begin
      case (state_q)
        HUNT: begin
          if (DIN == PRE_WORD) begin
            state_d   = PRE;
            pre_cnt_d = PC_W'(1);
          end
        end
        PRE: begin
          if (DIN == PRE_WORD) begin
            // Long preambles are legal, so the count just saturates.
            if (pre_cnt_q < PRE_MIN) pre_cnt_d = pre_cnt_q + PC_W'(1);
          end else if (DIN == MARK_WORD) begin
            if (pre_cnt_q >= PRE_MIN) begin
              state_d = PAYLOAD;
              idx_d   = '0;
            end else begin
              state_d = HUNT;
              err_d   = 1'b1;
            end
          end else begin
            state_d = HUNT;
          end
        end
        PAYLOAD: begin
          // Sync words inside the payload are plain data; no resync here.
          valid_d   = 1'b1;
          data_d    = DIN;
          pix_idx_d = idx_q;
          first_d   = (idx_q == '0);
          if (idx_q == LAST_IDX) begin
            last_d     = 1'b1;
            line_cnt_d = line_cnt_q + LCNT_W'(1);
            idx_d      = '0;
            state_d    = HUNT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State and output registers; reset aborts any line in progress.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= HUNT;
      pre_cnt_q  <= '0;
      idx_q      <= '0;
      pix_idx_q  <= '0;
      line_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      idx_q      <= idx_d;
      pix_idx_q  <= pix_idx_d;
      line_cnt_q <= line_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      first_q    <= first_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

  assign PIXEL_VALID = valid_q;
  assign PIXEL_DATA  = data_q;
  assign PIXEL_FIRST = first_q;
  assign PIXEL_LAST  = last_q;
  assign PIXEL_INDEX = pix_idx_q;
  assign LINE_CNT    = line_cnt_q;
  assign SYNC_ERR    = err_q;

endmodule

// File: tb/tb_pick_sync.sv
// tb/tb_pick_sync.sv - directed self-checking bench for pick_sync
module tb_pick_sync;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        EN;
  logic [15:0] DIN;
  logic        PIXEL_VALID, PIXEL_FIRST, PIXEL_LAST, SYNC_ERR;
  logic [15:0] PIXEL_DATA;
  logic [3:0]  PIXEL_INDEX;
  logic [7:0]  LINE_CNT;

  logic        w_valid, w_first, w_last, w_err;
  logic [15:0] w_data;
  logic [3:0]  w_index;
  logic [1:0]  w_line_cnt;

  int n_chk = 0;
  int n_err = 0;
  int pix_cnt;
  int err_cnt;

  always #5 CLK = ~CLK;

  pick_sync u_dut (
    .CLK(CLK), .nRST(nRST), .EN(EN), .DIN(DIN),
    .PIXEL_VALID(PIXEL_VALID), .PIXEL_DATA(PIXEL_DATA), .PIXEL_FIRST(PIXEL_FIRST),
    .PIXEL_LAST(PIXEL_LAST), .PIXEL_INDEX(PIXEL_INDEX), .LINE_CNT(LINE_CNT),
    .SYNC_ERR(SYNC_ERR)
  );

  pick_sync #(.LCNT_W(2)) u_wrap (
    .CLK(CLK), .nRST(nRST), .EN(EN), .DIN(DIN),
    .PIXEL_VALID(w_valid), .PIXEL_DATA(w_data), .PIXEL_FIRST(w_first),
    .PIXEL_LAST(w_last), .PIXEL_INDEX(w_index), .LINE_CNT(w_line_cnt),
    .SYNC_ERR(w_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [15:0] w);
    @(negedge CLK);
    EN  = en;
    DIN = w;
    @(posedge CLK);
    #1;
    if (PIXEL_VALID) pix_cnt++;
    if (SYNC_ERR) err_cnt++;
  endtask

  task automatic idle(input logic [15:0] w);
    drive(1'b1, w);
    check("no_valid", PIXEL_VALID, 0);
  endtask

  task automatic header(input int npre);
    for (int i = 0; i < npre; i++) idle(16'hFFFF);
    idle(16'hAAAA);
  endtask

  task automatic pix(input logic [15:0] w, input int idx);
    drive(1'b1, w);
    check("pix_valid", PIXEL_VALID, 1);
    check("pix_data",  PIXEL_DATA, w);
    check("pix_index", PIXEL_INDEX, idx);
    check("pix_first", PIXEL_FIRST, (idx == 0) ? 1 : 0);
    check("pix_last",  PIXEL_LAST, (idx == 15) ? 1 : 0);
  endtask

  task automatic line(input int npre, input logic [15:0] base);
    header(npre);
    for (int i = 0; i < 16; i++) pix(base + 16'(i), i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, PIXEL_VALID, 0);
    check({tag, "_first"}, PIXEL_FIRST, 0);
    check({tag, "_last"},  PIXEL_LAST, 0);
    check({tag, "_err"},   SYNC_ERR, 0);
    check({tag, "_data"},  PIXEL_DATA, 0);
    check({tag, "_index"}, PIXEL_INDEX, 0);
    check({tag, "_lcnt"},  LINE_CNT, 0);
    check({tag, "_wlcnt"}, w_line_cnt, 0);
  endtask

  initial begin
    nRST = 1'b0;
    EN   = 1'b0;
    DIN  = 16'h0000;
    pix_cnt = 0;
    err_cnt = 0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    @(negedge CLK);
    nRST = 1'b1;

    // Nominal line
    pix_cnt = 0; err_cnt = 0;
    idle(16'h0000);
    line(2, 16'hAAAB);
    check("nom_pixels", pix_cnt, 16);
    check("nom_lcnt", LINE_CNT, 1);
    check("nom_err", err_cnt, 0);

    // Back-to-back lines
    pix_cnt = 0;
    for (int l = 0; l < 3; l++) begin
      for (int k = 0; k < 4; k++) idle(16'h0000);
      line(2, 16'hAAAB);
    end
    check("b2b_pixels", pix_cnt, 48);
    check("b2b_lcnt", LINE_CNT, 4);

    // Short preamble, then a long valid one
    pix_cnt = 0; err_cnt = 0;
    idle(16'hFFFF);
    drive(1'b1, 16'hAAAA);
    check("short_err_pulse", SYNC_ERR, 1);
    check("short_no_valid", PIXEL_VALID, 0);
    drive(1'b1, 16'h1234);
    check("short_err_end", SYNC_ERR, 0);
    idle(16'h5678);
    idle(16'h9ABC);
    check("short_err_count", err_cnt, 1);
    check("short_pixels", pix_cnt, 0);
    line(3, 16'h0100);
    check("short_line_pixels", pix_cnt, 16);
    check("short_lcnt", LINE_CNT, 5);

    // EN stall after index 5
    pix_cnt = 0;
    header(2);
    for (int i = 0; i < 6; i++) pix(16'h2000 + 16'(i), i);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 16'hDEAD);
      check("stall_valid", PIXEL_VALID, 0);
      check("stall_first", PIXEL_FIRST, 0);
      check("stall_last", PIXEL_LAST, 0);
    end
    for (int i = 6; i < 16; i++) pix(16'h2000 + 16'(i), i);
    check("stall_pixels", pix_cnt, 16);
    check("stall_lcnt", LINE_CNT, 6);

    // Sync words inside the payload
    pix_cnt = 0; err_cnt = 0;
    header(2);
    for (int i = 0; i < 16; i++) begin
      if (i == 3 || i == 4) pix(16'hFFFF, i);
      else if (i == 5) pix(16'hAAAA, i);
      else pix(16'h3000 + 16'(i), i);
    end
    idle(16'h0000);
    check("sync_pixels", pix_cnt, 16);
    check("sync_err", err_cnt, 0);
    check("sync_lcnt", LINE_CNT, 7);
    check("wrap_lcnt_7", w_line_cnt, 3);

    // Reset mid-payload at index 8
    header(2);
    for (int i = 0; i < 9; i++) pix(16'h4000 + 16'(i), i);
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("held_rst");
    @(negedge CLK);
    nRST = 1'b1;
    pix_cnt = 0;
    line(2, 16'hAAAB);
    check("rst_pixels", pix_cnt, 16);
    check("rst_lcnt", LINE_CNT, 1);

    // Four more lines: 5 since reset, 2-bit counter wraps to 1
    for (int l = 0; l < 4; l++) begin
      idle(16'h0000);
      line(2, 16'h5000 + 16'(l * 16));
    end
    check("wrap_main_lcnt", LINE_CNT, 5);
    check("wrap_lcnt", w_line_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pick_sync.md
# pick_sync

Parametrised successor to the fixed-format pixel picker. It watches a raw word stream on `DIN` and hunts for a sync header: at least `PRE_CNT` consecutive `PRE_WORD` words followed by one `MARK_WORD`. It then emits the next `PAYLOAD_LEN` words as qualified pixels with first/last/index sideband. It also keeps a line counter and flags malformed headers. It sits between the sensor word interface and the pixel FIFO/line buffer.

## Interface
Parameters:
- `DATA_W`, 16: width of `DIN` and `PIXEL_DATA`.
- `PRE_WORD`, 16'hFFFF: preamble word value.
- `PRE_CNT`, 2: minimum number of consecutive preamble words. Must be ≥1.
- `MARK_WORD`, 16'hAAAA: start-of-payload marker. Must differ from `PRE_WORD`.
- `PAYLOAD_LEN`, 16: pixels per line. Must be ≥2.
- `LCNT_W`, 8: width of the line counter.

Ports:
- `CLK`  in  1: clock. Single clock domain, rising edge.
- `nRST`  in  1: asynchronous, active-low reset.
- `EN`  in  1: stream qualifier. When low, `DIN` is ignored for that cycle.
- `DIN`  in  `DATA_W`: raw input word, sampled on the rising edge of `CLK`.
- `PIXEL_VALID`  out  1: pixel strobe.
- `PIXEL_DATA`  out  `DATA_W`: pixel word.
- `PIXEL_FIRST`  out  1: high with index-0 pixel.
- `PIXEL_LAST`  out  1: high with index `PAYLOAD_LEN-1` pixel.
- `PIXEL_INDEX`  out  `$clog2(PAYLOAD_LEN)`: pixel position in the line.
- `LINE_CNT`  out  `LCNT_W`: completed lines since reset. Wraps modulo 2^`LCNT_W`.
- `SYNC_ERR`  out  1: one-cycle pulse flagging a short preamble.

## Operation
- FSM states: HUNT, PRE, PAYLOAD. Reset state is HUNT.
- All transitions and outputs advance only on edges where `EN`=1. On an `EN`=0 edge, state, counters and index hold. `PIXEL_VALID`, `PIXEL_FIRST`, `PIXEL_LAST` and `SYNC_ERR` are driven 0 on that edge.
- HUNT:
  - `DIN`==`PRE_WORD` → PRE, with the preamble counter set to 1.
  - Any other word → stay in HUNT.
- PRE:
  - `DIN`==`PRE_WORD` → stay in PRE. The preamble counter increments, saturating at `PRE_CNT`. Extra preamble words are legal.
  - `DIN`==`MARK_WORD` with counter ≥`PRE_CNT` → PAYLOAD, with the pixel index set to 0.
  - `DIN`==`MARK_WORD` with counter <`PRE_CNT` → HUNT, with `SYNC_ERR` pulsed.
  - Any other word → HUNT, with no error.
- PAYLOAD:
  - Each enabled word is emitted with `PIXEL_VALID`=1 and `PIXEL_INDEX`=current index. The index then increments.
  - Words equal to `PRE_WORD` or `MARK_WORD` are treated as ordinary payload; no resync occurs.
  - On the word at index `PAYLOAD_LEN-1`: `PIXEL_LAST`=1, `LINE_CNT` increments, next state is HUNT.
  - `PIXEL_FIRST` = (index==0).
- Width rules:
  - `PIXEL_DATA` is `DIN` unmodified.
  - The preamble counter is `$clog2(PRE_CNT+1)` bits.
  - `LINE_CNT` wraps from 2^`LCNT_W`-1 to 0 with no flag.
- Reset values: `PIXEL_VALID`, `PIXEL_FIRST`, `PIXEL_LAST`, `SYNC_ERR` = 0; `PIXEL_DATA`, `PIXEL_INDEX`, `LINE_CNT` = 0; state = HUNT.
- Reset asserted mid-payload aborts the line. All outputs return to their reset values immediately (asynchronously). No partial-line `PIXEL_LAST` is generated.

## Timing
- All outputs are registered. A word sampled at edge n appears on `PIXEL_DATA`/`PIXEL_VALID` from edge n until edge n+1: one cycle of latency after `DIN` is set up.
- The marker is sampled at edge m. The first pixel is the word sampled at edge m+1, and `PIXEL_VALID` is first high after edge m+1.
- With `EN` held high, the pixels are contiguous: `PAYLOAD_LEN` consecutive valid cycles.
- `SYNC_ERR` is high for exactly the one cycle following the offending marker edge.
- The earliest new header may start on the edge after the `PIXEL_LAST` word. That edge is in HUNT, so a preamble word there is accepted.
- `PIXEL_DATA`/`PIXEL_INDEX` are don't-care when `PIXEL_VALID`=0. In practice they hold their last value.

## Test plan
- **Nominal line** (default parameters): stimulus is 0000 idle, FFFF, FFFF, AAAA, then AAAB incrementing to AABA (16 words). Required response:
  - exactly 16 valid pixels, AAAB..AABA, with index 0..15;
  - `PIXEL_FIRST` on AAAB and `PIXEL_LAST` on AABA;
  - `LINE_CNT` 0→1;
  - no `SYNC_ERR`.
- **Back-to-back lines**: repeat the nominal line 3 times with 4 idle words between. Required response: 48 pixels total, `LINE_CNT`=3, each line's index restarts at 0.
- **Short preamble**: stimulus FFFF, AAAA, then data. Required response: `SYNC_ERR` single-cycle pulse, no `PIXEL_VALID`. A following valid header (FFFF, FFFF, FFFF, AAAA) yields a normal line.
- **EN stall**: drop `EN` for 3 cycles after pixel index 5 of a line. Required response:
  - `PIXEL_VALID` low for those 3 cycles;
  - the pixel after the stall has index 6 and data equal to the next enabled word;
  - still 16 pixels in total.
- **Sync words in payload**: payload containing FFFF, FFFF, AAAA at indices 3–5. Required response: those words emitted as pixels, line length stays 16, no resync.
- **Reset and wrap**:
  - Assert `nRST` low at pixel index 8, then release and send a nominal line. Required response: all outputs 0 during reset, the next line starts at index 0, and `LINE_CNT`=1.
  - With `LCNT_W`=2, 5 lines → `LINE_CNT`=1.
